// File: rtl/clk_div_multi.sv
// clk_div_multi: run-time programmable multi-channel 50 % duty clock divider.
// Each channel counts Clk edges up to its active half-period, toggles its
// output there and emits a one-cycle tick on every rising output edge.
// New half-periods are staged in a shadow register and adopted only at a
// terminal count (or while the channel is disabled), so no runt or stretched
// half-cycle is ever produced.
module clk_div_multi #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int N_CH         = 4,
   parameter int CNT_W        = 26,
   parameter int DEFAULT_HALF = CLK_HZ / 2,
   parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [N_CH-1:0]   En,
   input  logic              DivLoad,
   input  logic [CH_W-1:0]   DivCh,
   input  logic [CNT_W-1:0]  DivValue,
   output logic [N_CH-1:0]   ClkOut,
   output logic [N_CH-1:0]   Tick,
   output logic              LoadErr
);

   localparam int CH_MIN = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CNT_W-1:0] DEF_HALF_L = CNT_W'(DEFAULT_HALF);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
   localparam logic [CH_W:0]    N_CH_L     = (CH_W + 1)'(N_CH);

   // Parameter sanity: channel count, select width and reset half-period fit.
   if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
      $error("clk_div_multi: N_CH must be in 1..16");
   end
   if (CH_W < CH_MIN) begin : g_bad_chw
      $error("clk_div_multi: CH_W too narrow for N_CH");
   end
   if (CLK_HZ < 1 || DEFAULT_HALF < 1 ||
       longint'(DEFAULT_HALF) >= (longint'(1) << CNT_W)) begin : g_bad_def
      $error("clk_div_multi: DEFAULT_HALF must be in 1..2**CNT_W-1");
   end

   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [CNT_W-1:0] act_q [N_CH];
   logic [CNT_W-1:0] act_d [N_CH];
   logic [CNT_W-1:0] shd_q [N_CH];
   logic [CNT_W-1:0] shd_d [N_CH];
   logic [N_CH-1:0]  clk_q, clk_d;
   logic [N_CH-1:0]  tick_q, tick_d;
   logic             err_q, err_d;

   logic [CNT_W-1:0] load_val;
   logic             ch_ok;

   // A zero half-period would never terminate; it is promoted to one.
   assign load_val = (DivValue == '0) ? ONE : DivValue;
   assign ch_ok    = ({1'b0, DivCh} < N_CH_L);

   // Next-state: shadow load, then per-channel disable / terminal / count.
   always_comb begin
      err_d = DivLoad & ~ch_ok;
      for (int i = 0; i < N_CH; i++) begin
         shd_d[i]  = shd_q[i];
         act_d[i]  = act_q[i];
         cnt_d[i]  = cnt_q[i];
         clk_d[i]  = clk_q[i];
         tick_d[i] = 1'b0;
         if (DivLoad && ch_ok && (DivCh == CH_W'(i))) begin
            shd_d[i] = load_val;
         end
         if (!En[i]) begin
            cnt_d[i] = ONE;
            clk_d[i] = 1'b0;
            act_d[i] = shd_d[i];
         end else if (cnt_q[i] == act_q[i]) begin
            // Terminal count: toggle and adopt the staged half-period,
            // including one loaded on this very edge.
            clk_d[i]  = ~clk_q[i];
            tick_d[i] = ~clk_q[i];
            cnt_d[i]  = ONE;
            act_d[i]  = shd_d[i];
         end else begin
            cnt_d[i] = cnt_q[i] + ONE;
         end
      end
   end

   // State registers; reset restores the default rate on every channel.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= ONE;
            act_q[i] <= DEF_HALF_L;
            shd_q[i] <= DEF_HALF_L;
         end
         clk_q  <= '0;
         tick_q <= '0;
         err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            act_q[i] <= act_d[i];
            shd_q[i] <= shd_d[i];
         end
         clk_q  <= clk_d;
         tick_q <= tick_d;
         err_q  <= err_d;
      end
   end

   assign ClkOut  = clk_q;
   assign Tick    = tick_q;
   assign LoadErr = err_q;

endmodule
